// File: rtl/m68k_bus_pkg.sv
// Shared types for the PI-to-68k request queue: size codes, bus FSM states,
// the queued request record and the data-strobe lane helper.
package m68k_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_ASRT  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_LATCH = 3'd5,
    ST_END   = 3'd6
  } bus_state_t;

  // addr is held at 32 bits so the record is independent of the bus width
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        rw;
    logic [2:0]  fc;
  } bus_req_t;

  // Returns {UDS_n, LDS_n}; only bytes select a single lane, on A0.
  function automatic logic [1:0] lane_strobes(input logic [1:0] size, input logic a0);
    logic [1:0] lanes;
    lanes = 2'b00;
    if (size == SZ_BYTE) lanes = a0 ? 2'b10 : 2'b01;
    return lanes;
  endfunction

endpackage

// File: rtl/m68k_req_fifo.sv
// Request FIFO: DEPTH entries of bus_req_t, registered full/empty flags,
// one push port and one pop port. A push at full is dropped even with a pop.
module m68k_req_fifo
  import m68k_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  bus_req_t i_push_data,
  input  logic     i_pop,
  output bus_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PW = $clog2(DEPTH);

  bus_req_t       r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  logic           r_full;
  logic           r_empty;
  logic           w_do_push;
  logic           w_do_pop;
  logic [PW:0]    w_count_nxt;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) w_count_nxt = r_count + (PW+1)'(1);
    else if (!w_do_push && w_do_pop) w_count_nxt = r_count - (PW+1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/m68k_bus_queue.sv
// Queued PI-to-68000 bus bridge: requests run as S0-S7 bus cycles paced by
// synchronised M68K_CLK edges, with long split into two words, DTACK timeout and BERR.
module m68k_bus_queue
  import m68k_bus_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              PI_CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_rw,
  input  logic [2:0]        req_fc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_berr,
  output logic              busy,
  input  logic              M68K_CLK,
  input  logic              M68K_DTACK_n,
  input  logic              M68K_BERR_n,
  input  logic [15:0]       M68K_D_IN,
  output logic [ADDR_W-2:0] M68K_A,
  output logic [15:0]       M68K_D_OUT,
  output logic              M68K_D_OE,
  output logic [2:0]        M68K_FC,
  output logic              M68K_AS_n,
  output logic              M68K_UDS_n,
  output logic              M68K_LDS_n,
  output logic              M68K_RW,
  output bus_state_t        dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  bus_state_t             r_state;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [1:0]             r_dtack_sync;
  logic [1:0]             r_berr_sync;
  logic [ADDR_W-1:0]      r_addr;
  logic [31:0]            r_wdata;
  logic [1:0]             r_size;
  logic                   r_rw_req;
  logic                   r_half;
  logic [31:0]            r_rdata;
  logic                   r_berr;
  logic [TW-1:0]          r_tcnt;
  logic                   r_as_n, r_uds_n, r_lds_n, r_rw, r_d_oe;
  logic [15:0]            r_d_out;
  logic [2:0]             r_fc;
  logic                   r_rsp_valid, r_rsp_berr;
  logic [31:0]            r_rsp_rdata;

  bus_req_t               w_push_req;
  bus_req_t               w_head;
  logic                   w_full, w_empty, w_pop;
  logic                   w_rise, w_fall;
  logic [1:0]             w_lanes;
  logic [15:0]            w_wdata_out;
  logic [TW-1:0]          w_tcnt_nxt;
  logic                   w_timeout;
  logic                   w_unused_addr;

  assign w_push_req = '{addr: 32'(req_addr), wdata: req_wdata, size: req_size,
                        rw: req_rw, fc: req_fc};

  m68k_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (PI_CLK),
    .i_rst       (RST),
    .i_push      (req_valid),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Upper address bits beyond ADDR_W are always zero in the queue.
  assign w_unused_addr = ^w_head.addr;

  always_ff @(posedge PI_CLK or posedge RST) begin
    if (RST) begin
      r_clk_sync   <= '0;
      r_dtack_sync <= 2'b11;
      r_berr_sync  <= 2'b11;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], M68K_CLK};
      r_dtack_sync <= {r_dtack_sync[0], M68K_DTACK_n};
      r_berr_sync  <= {r_berr_sync[0], M68K_BERR_n};
    end
  end

  assign w_rise = r_clk_sync[SYNC_STAGES-2] & ~r_clk_sync[SYNC_STAGES-1];
  assign w_fall = ~r_clk_sync[SYNC_STAGES-2] & r_clk_sync[SYNC_STAGES-1];
  assign w_pop  = (r_state == ST_IDLE) & w_rise & ~w_empty;

  assign w_lanes    = lane_strobes(r_size, r_addr[0]);
  assign w_tcnt_nxt = r_tcnt + TW'(1);
  assign w_timeout  = (w_tcnt_nxt == TW'(TIMEOUT_CYC));

  always_comb begin
    w_wdata_out = r_wdata[15:0];
    if (r_size == SZ_BYTE) w_wdata_out = {r_wdata[7:0], r_wdata[7:0]};
    else if (r_size == SZ_LONG && !r_half) w_wdata_out = r_wdata[31:16];
  end

  always_ff @(posedge PI_CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= SZ_WORD;
      r_rw_req    <= 1'b1;
      r_half      <= 1'b0;
      r_rdata     <= '0;
      r_berr      <= 1'b0;
      r_tcnt      <= '0;
      r_as_n      <= 1'b1;
      r_uds_n     <= 1'b1;
      r_lds_n     <= 1'b1;
      r_rw        <= 1'b1;
      r_d_oe      <= 1'b0;
      r_d_out     <= '0;
      r_fc        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_berr  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_pop) begin
          r_addr   <= w_head.addr[ADDR_W-1:0];
          r_wdata  <= w_head.wdata;
          r_size   <= w_head.size;
          r_rw_req <= w_head.rw;
          r_fc     <= w_head.fc;
          r_rw     <= 1'b1;
          r_half   <= 1'b0;
          r_rdata  <= '0;
          r_berr   <= 1'b0;
          r_state  <= ST_ADDR;
        end
        ST_ADDR: if (w_fall) begin
          r_as_n <= 1'b0;
          if (r_rw_req) {r_uds_n, r_lds_n} <= w_lanes;
          r_state <= ST_ASRT;
        end
        ST_ASRT: if (w_rise) begin
          r_rw <= r_rw_req;
          if (!r_rw_req) begin
            r_d_out <= w_wdata_out;
            r_d_oe  <= 1'b1;
          end
          r_state <= ST_DATA;
        end
        ST_DATA: if (w_fall) begin
          if (!r_rw_req) {r_uds_n, r_lds_n} <= w_lanes;
          r_tcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (w_fall) begin
          // BERR wins over DTACK when both are seen on the same edge
          if (!r_berr_sync[1]) begin
            r_berr  <= 1'b1;
            r_state <= ST_LATCH;
          end else if (!r_dtack_sync[1]) begin
            r_state <= ST_LATCH;
          end else if (w_timeout) begin
            r_berr  <= 1'b1;
            r_state <= ST_LATCH;
          end else begin
            r_tcnt <= w_tcnt_nxt;
          end
        end
        ST_LATCH: if (w_fall) begin
          if (r_rw_req) begin
            if (r_size == SZ_BYTE)
              r_rdata <= {24'h0, r_addr[0] ? M68K_D_IN[7:0] : M68K_D_IN[15:8]};
            else if (r_size == SZ_LONG && r_half) r_rdata[15:0] <= M68K_D_IN;
            else if (r_size == SZ_LONG) r_rdata[31:16] <= M68K_D_IN;
            else r_rdata <= {16'h0, M68K_D_IN};
          end
          r_as_n  <= 1'b1;
          r_uds_n <= 1'b1;
          r_lds_n <= 1'b1;
          r_state <= ST_END;
        end
        ST_END: if (w_rise) begin
          r_d_oe <= 1'b0;
          r_rw   <= 1'b1;
          if (r_size == SZ_LONG && !r_half && !r_berr) begin
            r_half  <= 1'b1;
            r_addr  <= r_addr + ADDR_W'(2);
            r_state <= ST_ADDR;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_rdata;
            r_rsp_berr  <= r_berr;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = ~w_full;
  assign busy       = ~w_empty | (r_state != ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_berr   = r_rsp_berr;
  assign M68K_A     = r_addr[ADDR_W-1:1];
  assign M68K_D_OUT = r_d_out;
  assign M68K_D_OE  = r_d_oe;
  assign M68K_FC    = r_fc;
  assign M68K_AS_n  = r_as_n;
  assign M68K_UDS_n = r_uds_n;
  assign M68K_LDS_n = r_lds_n;
  assign M68K_RW    = r_rw;
  assign dbg_state  = r_state;

endmodule
